// File: rtl/img_pkg.sv
// Shared pixel and window types plus the window generator state encoding.
package img_pkg;
    localparam int PIX_W = 12;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef logic [3*PIX_W-1:0] win_row_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pwg_state_t;
endpackage

// File: rtl/pwg_line_buf.sv
// Two-row line buffer {row y-2, row y-1}, one entry per column.
// Asynchronous read with synchronous write gives read-before-write at a shared address.
module pwg_line_buf
    import img_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_addr,
    input  logic [2*PIX_W-1:0] i_wdata,
    output logic [2*PIX_W-1:0] o_rdata
);
    logic [2*PIX_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/pixel_window_gen.sv
// Raster pixel streamer emitting registered 3x3 RGB444 windows for interior pixels.
// Optional PWG_COORD_EN adds win_x/win_y centre-coordinate outputs.
module pixel_window_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int XW = $clog2(IMG_WIDTH),
    localparam int YW = $clog2(IMG_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  pixel_t        pix_in,
    input  logic          pix_in_vld,
    output logic          pix_in_rdy,
    output win_row_t      win_row0,
    output win_row_t      win_row1,
    output win_row_t      win_row2,
    output logic          win_vld,
    input  logic          win_rdy,
    output logic          frame_done
`ifdef PWG_COORD_EN
    ,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y
`endif
);
    pwg_state_t           r_state;
    logic [XW-1:0]        r_x;
    logic [YW-1:0]        r_y;
    win_row_t             r_col_a;
    win_row_t             r_col_b;

    logic                 w_accept;
    logic                 w_last_x;
    logic                 w_last_y;
    logic                 w_win_load;
    logic                 w_hs;
    logic [2*PIX_W-1:0]   w_lb_rd;
    pixel_t               w_lb0;
    pixel_t               w_lb1;

    assign pix_in_rdy = (r_state == RUN) && (!win_vld || win_rdy);
    assign w_accept   = pix_in_vld && pix_in_rdy;
    assign w_last_x   = (r_x == XW'(IMG_WIDTH - 1));
    assign w_last_y   = (r_y == YW'(IMG_HEIGHT - 1));
    assign w_win_load = w_accept && (r_x >= XW'(2)) && (r_y >= YW'(2));
    assign w_hs       = win_vld && win_rdy;
    assign {w_lb0, w_lb1} = w_lb_rd;

    pwg_line_buf #(
        .DEPTH (IMG_WIDTH),
        .AW    (XW)
    ) u_line_buf (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (r_x),
        .i_wdata ({w_lb1, pix_in}),
        .o_rdata (w_lb_rd)
    );

    // Columns x-2 and x-1 of the neighbourhood, each packed {top, mid, bottom}
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_col_a <= r_col_b;
            r_col_b <= {w_lb0, w_lb1, pix_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_row0 <= '0;
            win_row1 <= '0;
            win_row2 <= '0;
            win_vld  <= 1'b0;
`ifdef PWG_COORD_EN
            win_x    <= '0;
            win_y    <= '0;
`endif
        end else if (w_win_load) begin
            win_row0 <= {r_col_a[3*PIX_W-1:2*PIX_W], r_col_b[3*PIX_W-1:2*PIX_W], w_lb0};
            win_row1 <= {r_col_a[2*PIX_W-1:PIX_W],   r_col_b[2*PIX_W-1:PIX_W],   w_lb1};
            win_row2 <= {r_col_a[PIX_W-1:0],         r_col_b[PIX_W-1:0],         pix_in};
            win_vld  <= 1'b1;
`ifdef PWG_COORD_EN
            win_x    <= r_x - XW'(1);
            win_y    <= r_y - YW'(1);
`endif
        end else if (w_hs) begin
            win_vld  <= 1'b0;
        end
    end

    // The last pixel always loads a window, so DRAIN waits for exactly one handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_y        <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        if (w_last_x) begin
                            r_x <= '0;
                            if (w_last_y) begin
                                r_y     <= '0;
                                r_state <= DRAIN;
                            end else begin
                                r_y <= r_y + YW'(1);
                            end
                        end else begin
                            r_x <= r_x + XW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (w_hs) begin
                        r_state    <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_window_gen.sv
// Scoreboard bench for pixel_window_gen on a 4x4 frame; windows are predicted from a 2-D image array.
module tb_pixel_window_gen;
    import img_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic     clk = 1'b0;
    logic     rst;
    logic     start;
    pixel_t   pix_in;
    logic     pix_in_vld;
    logic     pix_in_rdy;
    win_row_t win_row0;
    win_row_t win_row1;
    win_row_t win_row2;
    logic     win_vld;
    logic     win_rdy;
    logic     frame_done;
`ifdef PWG_COORD_EN
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
`endif

    always #5 clk = ~clk;

    pixel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_in     (pix_in),
        .pix_in_vld (pix_in_vld),
        .pix_in_rdy (pix_in_rdy),
        .win_row0   (win_row0),
        .win_row1   (win_row1),
        .win_row2   (win_row2),
        .win_vld    (win_vld),
        .win_rdy    (win_rdy),
        .frame_done (frame_done)
`ifdef PWG_COORD_EN
        ,
        .win_x      (win_x),
        .win_y      (win_y)
`endif
    );

    typedef struct packed {
        win_row_t   r0;
        win_row_t   r1;
        win_row_t   r2;
        logic [7:0] cx;
        logic [7:0] cy;
    } exp_t;

    exp_t     exp_q[$];
    pixel_t   img [H][W];
    int       n_pass = 0;
    int       n_chk = 0;
    int       n_pop_frame = 0;
    int       n_done = 0;
    int       rdy_mode = 0;
    int       stall_cnt = 0;
    win_row_t first_r0, first_r1, first_r2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    // Reference: fill the image, then list every interior 3x3 neighbourhood in raster order
    task automatic build_frame(input int base, input bit rnd);
        exp_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = rnd ? pixel_t'($urandom) : pixel_t'(base + y * W + x);
        for (int cy = 1; cy <= H - 2; cy++) begin
            for (int cx = 1; cx <= W - 2; cx++) begin
                e.r0 = {img[cy-1][cx-1], img[cy-1][cx], img[cy-1][cx+1]};
                e.r1 = {img[cy][cx-1],   img[cy][cx],   img[cy][cx+1]};
                e.r2 = {img[cy+1][cx-1], img[cy+1][cx], img[cy+1][cx+1]};
                e.cx = 8'(cx);
                e.cy = 8'(cy);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic set_rdy();
        case (rdy_mode)
            0: win_rdy = 1'b1;
            1: begin
                if (win_vld && n_pop_frame == 1 && stall_cnt < 5) begin
                    win_rdy = 1'b0;
                    stall_cnt++;
                end else begin
                    win_rdy = 1'b1;
                end
            end
            default: win_rdy = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // Monitor: pops one expected window per observed handshake
    initial begin
        exp_t     e;
        win_row_t h0, h1, h2;
        bit       held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (win_vld) begin
                    if (held) begin
                        chk("hold_row0", win_row0, h0);
                        chk("hold_row1", win_row1, h1);
                        chk("hold_row2", win_row2, h2);
                    end
                    if (!win_rdy) begin
                        chk("pix_in_rdy_during_stall", pix_in_rdy, 0);
                        h0 = win_row0; h1 = win_row1; h2 = win_row2;
                        held = 1'b1;
                    end else begin
                        held = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("win_vld_without_expected", win_vld, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("win_row0", win_row0, e.r0);
                            chk("win_row1", win_row1, e.r1);
                            chk("win_row2", win_row2, e.r2);
`ifdef PWG_COORD_EN
                            chk("win_x", win_x, e.cx);
                            chk("win_y", win_y, e.cy);
`endif
                            if (n_pop_frame == 0) begin
                                first_r0 = win_row0; first_r1 = win_row1; first_r2 = win_row2;
                            end
                            n_pop_frame++;
                        end
                    end
                end else begin
                    held = 1'b0;
                end
                if (frame_done) begin
                    chk("frame_done_queue_empty", exp_q.size(), 0);
                    chk("frame_done_pix_in_rdy", pix_in_rdy, 0);
                    n_done++;
                end
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_win_vld"}, win_vld, 0);
        chk({tag, "_pix_in_rdy"}, pix_in_rdy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_row0"}, win_row0, 0);
        chk({tag, "_row1"}, win_row1, 0);
        chk({tag, "_row2"}, win_row2, 0);
    endtask

    // Entered and left at posedge+1
    task automatic run_frame(input int base, input bit rnd_data, input bit rnd_vld,
                             input int mode, input int abort_after, input int start_at);
        int idx = 0;
        int guard = 0;
        int done0;
        bit acc;
        build_frame(base, rnd_data);
        n_pop_frame = 0;
        stall_cnt = 0;
        rdy_mode = mode;
        done0 = n_done;
        start = 1'b1;
        set_rdy();
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < W * H) begin
            set_rdy();
            start = (idx == start_at);
            #1;
            if (pix_in_rdy && (!rnd_vld || $urandom_range(0, 3) != 0)) begin
                pix_in = img[idx / W][idx % W];
                pix_in_vld = 1'b1;
                acc = 1'b1;
            end else begin
                pix_in = pixel_t'($urandom);
                pix_in_vld = pix_in_rdy ? 1'b0 : 1'($urandom_range(0, 1));
                acc = 1'b0;
            end
            @(posedge clk); #1;
            pix_in_vld = 1'b0;
            start = 1'b0;
            if (acc) idx++;
            guard++;
            if (guard > 1000) begin
                $display("FAIL pixel_accept_timeout: accepted %0d required %0d", idx, W * H);
                $fatal(1, "pixel acceptance stalled");
            end
            if (idx == abort_after) break;
        end
        if (idx == abort_after) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_idle_outputs("after_abort");
            exp_q.delete();
            win_rdy = 1'b1;
            for (int i = 0; i < 5; i++) begin
                pix_in_vld = 1'($urandom_range(0, 1));
                pix_in = pixel_t'($urandom);
                #1;
                chk("abort_idle_pix_in_rdy", pix_in_rdy, 0);
                @(posedge clk); #1;
            end
            pix_in_vld = 1'b0;
            chk("abort_no_frame_done", n_done - done0, 0);
        end else begin
            guard = 0;
            while (n_done == done0 && guard < 200) begin
                set_rdy();
                @(posedge clk); #1;
                guard++;
            end
            chk("frame_done_pulses", n_done - done0, 1);
            chk("frame_done_one_cycle", frame_done, 0);
            chk("windows_in_frame", n_pop_frame, (W - 2) * (H - 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time %0t exceeded", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pix_in = '0;
        pix_in_vld = 1'b0;
        win_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(0, 1'b0, 1'b0, 0, -1, -1);
        chk("f1_first_row0", first_r0, 36'h000001002);
        chk("f1_first_row1", first_r1, 36'h004005006);
        chk("f1_first_row2", first_r2, 36'h00800900A);

        run_frame('h100, 1'b0, 1'b0, 0, -1, -1);
        chk("f2_first_row0", first_r0, 36'h100101102);
        chk("f2_first_row2", first_r2, 36'h10810910A);

        run_frame(0, 1'b0, 1'b0, 1, -1, -1);
        chk("stall_cycles", stall_cnt, 5);

        run_frame(0, 1'b1, 1'b1, 2, 10, -1);
        run_frame('h200, 1'b0, 1'b0, 0, -1, 5);
        chk("restart_first_row1", first_r1, 36'h204205206);

        for (int f = 0; f < 4; f++) begin
            run_frame(0, 1'b1, 1'b1, 2, -1, $urandom_range(1, 14));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pixel_window_gen.md
# pixel_window_gen

Raster-order pixel streamer that builds the 3x3 RGB neighbourhoods consumed by the coprocessor's grayscale converter and filter stages. It accepts one 12-bit RGB444 pixel per handshake, holds the two previous image rows in line buffers, and emits one registered 3x3 window per interior pixel. The window is emitted as three 36-bit rows in the exact bus format the converter expects.

## Interface
- IMG_WIDTH, 640: pixels per row; must be at least 3.
- IMG_HEIGHT, 480: rows per frame; must be at least 3.
- clk  in  1  sole clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle frame-start pulse; honoured only in IDLE.
- pix_in  in  12  RGB444 pixel as {R[11:8], G[7:4], B[3:0]}.
- pix_in_vld  in  1  pix_in is valid.
- pix_in_rdy  out  1  block accepts pix_in this cycle.
- win_row0  out  36  top window row (image row y-2), packed {left[35:24], mid[23:12], right[11:0]}.
- win_row1  out  36  middle row (y-1), same packing.
- win_row2  out  36  bottom row (y), same packing.
- win_vld  out  1  window outputs are valid.
- win_rdy  in  1  downstream accepts the window.
- frame_done  out  1  one-cycle pulse after the final window handshake.
- win_x, win_y  out  $clog2(IMG_WIDTH), $clog2(IMG_HEIGHT)  window centre coordinates; present only with PWG_COORD_EN.

## Operation
- States:
  - IDLE: start goes to RUN and clears the column counter x and row counter y to 0.
  - RUN: stays in RUN until the last pixel (x=W-1, y=H-1) is accepted, then goes to DRAIN.
  - DRAIN: on the win_vld && win_rdy handshake, goes to IDLE and pulses frame_done.
- pix_in_rdy = (state==RUN) && (!win_vld || win_rdy). It is low in IDLE and DRAIN.
- On each accepted pixel at column x, row y:
  - Read lb0[x] (row y-2) and lb1[x] (row y-1).
  - Shift the 3x3 register left one column; the new right column is {lb0[x], lb1[x], pix_in}.
  - Write lb0[x] <= lb1[x] and lb1[x] <= pix_in.
  - Advance x. When x wraps from W-1 to 0, advance y.
- A window is produced only when x>=2 and y>=2. Its centre is (x-1, y-1).
- Windows per frame: (W-2)*(H-2). No border windows are produced.
- When a pixel is accepted with x<2 or y<2, the shift register and line buffers update, but win_vld is not set by that pixel.
- Window outputs are held stable while win_vld && !win_rdy.
- win_vld clears on a handshake unless a new window loads in the same cycle.
- Pixel values pass through unmodified; no arithmetic is performed on pixel data.
- Reset values: state IDLE; pix_in_rdy, win_vld and frame_done are 0; win_row0/1/2 are 0; x and y are 0.
  - Line buffer contents are not reset. Rows 0 and 1 overwrite them before any read is used.
- Reset mid-frame aborts the frame immediately. No frame_done is pulsed, and a fresh start is required.
- start outside IDLE is ignored.
- pix_in_vld while pix_in_rdy is low is ignored, and no pixel is consumed.

## Timing
- Latency: a window appears one cycle after the acceptance edge of its bottom-right pixel.
- Throughput: one pixel per cycle when win_rdy is held high.
- Simultaneous handshake and new load: the output register takes the new window, and win_vld stays 1.
- Line buffer read and write occur in the same cycle at the same address. Read-before-write semantics are required.
- frame_done is asserted in the cycle after the final window's handshake edge, for exactly one cycle. pix_in_rdy stays 0 during that cycle.

## Configuration
- PWG_COORD_EN defined: win_x and win_y ports exist. They are registered alongside the window and hold its centre coordinates.
- PWG_COORD_EN undefined: the ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package img_pkg holds:
  - PIX_W=12
  - typedef pixel_t (12-bit)
  - typedef win_row_t (36-bit)
  - the state enum pwg_state_t {IDLE, RUN, DRAIN}
- Sub-module pwg_line_buf: IMG_WIDTH-deep, 24-bit-wide RAM holding {lb0, lb1}, with synchronous write and read-before-write. It is instantiated once.

## Test plan
- 4x4 frame, pixels 12'h000..12'h00F, win_rdy=1:
  - 1st window, after pixel 0x00A: row0=36'h000001002, row1=36'h004005006, row2=36'h00800900A.
  - 2nd window: rows {1,2,3}/{5,6,7}/{9,A,B}.
  - Exactly 4 windows total; frame_done pulses once after the 4th.
- Same frame with win_rdy low for 5 cycles on the 2nd window: outputs are held stable, pix_in_rdy=0 throughout, and no window is lost or duplicated.
- Run two frames back-to-back with distinct data (second frame 12'h100+i): the second frame's first window contains only second-frame pixels.
- Assert rst during row 2 of a 4x4 frame: next cycle all outputs are 0 and state is IDLE; no frame_done. A restarted frame produces the correct 4 windows.
- Pulse start during RUN: ignored, and counters are unchanged.
- Toggle pix_in_vld randomly while pix_in_rdy is low: no extra pixels are consumed.
- With PWG_COORD_EN, 5x4 frame: windows report (1,1), (2,1), (3,1), (1,2), (2,2), (3,2) in order.
